// File: rtl/pp_pipeline_accel_divsub_22s_21ns_10ns_8s_if.sv
// Handshake and data bundle for the divsub unit.
//   start  : request, accepted when ready and ce are high on a clock edge
//   din0   : p, 22-bit signed
//   din1   : b, 10-bit unsigned divisor
//   din2   : c, 21-bit unsigned offset
//   ready  : unit is idle
//   done   : one-cycle result-valid strobe
//   dout   : saturated signed 8-bit quotient
//   rem    : signed 11-bit remainder (sign follows the dividend)
//   ovf    : quotient was saturated
//   div0   : divisor was zero
interface pp_pipeline_accel_divsub_22s_21ns_10ns_8s_if;
  logic        start;
  logic [21:0] din0;
  logic [9:0]  din1;
  logic [20:0] din2;
  logic        ready;
  logic        done;
  logic [7:0]  dout;
  logic [10:0] rem;
  logic        ovf;
  logic        div0;

  modport master (
    output start, din0, din1, din2,
    input  ready, done, dout, rem, ovf, div0
  );

  modport slave (
    input  start, din0, din1, din2,
    output ready, done, dout, rem, ovf, div0
  );
endinterface

// File: rtl/pp_pipeline_accel_divsub_22s_21ns_10ns_8s.sv
// Iterative restoring divider recovering a = (p - c) / b from the muladd stage result.
// Produces a saturated signed 8-bit quotient plus the true signed remainder.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   ce    : global clock enable; all state holds while low
//   bus   : slave side of the start/ready/done handshake and data (see the _if file)
// One operation takes 22 CALC edges plus one FIX edge after the accept edge.
module pp_pipeline_accel_divsub_22s_21ns_10ns_8s #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 22,
  parameter int unsigned din1_WIDTH = 10,
  parameter int unsigned din2_WIDTH = 21,
  parameter int unsigned dout_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  pp_pipeline_accel_divsub_22s_21ns_10ns_8s_if.slave bus
);

  // Widths are fixed by the interface; the parameters exist only as instance tags.
  logic unused_params;
  assign unused_params = ^{ID, din0_WIDTH, din1_WIDTH, din2_WIDTH, dout_WIDTH};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [21:0] dvd_q, dvd_d;    // |D| shifts out the top while quotient bits shift in below
  logic [9:0]  div_q, div_d;
  logic [9:0]  prem_q, prem_d;  // partial remainder, always < b
  logic        done_q, done_d;
  logic [7:0]  dout_q, dout_d;
  logic [10:0] rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic        div0_q, div0_d;

  logic [22:0] dividend;
  logic [21:0] dividend_abs;
  logic [10:0] trial;
  logic        fits;
  logic        q_sat;

  // D = sext(p) - zext(c); |D| < 2^22 so the low 22 bits of the negation are exact.
  assign dividend     = {bus.din0[21], bus.din0} - {2'b00, bus.din2};
  assign dividend_abs = dividend[22] ? (~dividend[21:0] + 22'd1) : dividend[21:0];

  assign trial = {prem_q, dvd_q[21]};
  assign fits  = (trial >= {1'b0, div_q});

  // Negative quotients may reach -128 without clamping, positive ones only 127.
  assign q_sat = sign_q ? (dvd_q > 22'd128) : (dvd_q[21:7] != 15'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    prem_d  = prem_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sign_d  = dividend[22];
          dvd_d   = dividend_abs;
          div_d   = bus.din1;
          prem_d  = 10'd0;
          cnt_d   = 5'd21;
          state_d = StCalc;
        end
      end
      StCalc: begin
        // When fits, the difference is below b and so fits in 10 bits.
        prem_d = fits ? (trial[9:0] - div_q) : trial[9:0];
        dvd_d  = {dvd_q[20:0], fits};
        if (cnt_q == 5'd0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (div_q == 10'd0) begin
          div0_d = 1'b1;
          ovf_d  = 1'b0;
          rem_d  = 11'd0;
          dout_d = sign_q ? 8'h80 : 8'h7f;
        end else begin
          div0_d = 1'b0;
          ovf_d  = q_sat;
          rem_d  = sign_q ? (~{1'b0, prem_q} + 11'd1) : {1'b0, prem_q};
          if (sign_q) begin
            dout_d = q_sat ? 8'h80 : (~dvd_q[7:0] + 8'd1);
          end else begin
            dout_d = q_sat ? 8'h7f : dvd_q[7:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      sign_q  <= 1'b0;
      dvd_q   <= 22'd0;
      div_q   <= 10'd0;
      prem_q  <= 10'd0;
      done_q  <= 1'b0;
      dout_q  <= 8'd0;
      rem_q   <= 11'd0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      prem_q  <= prem_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.done  = done_q;
  assign bus.dout  = dout_q;
  assign bus.rem   = rem_q;
  assign bus.ovf   = ovf_q;
  assign bus.div0  = div0_q;

endmodule

// File: tb/tb_pp_pipeline_accel_divsub_22s_21ns_10ns_8s.sv
module tb_pp_pipeline_accel_divsub_22s_21ns_10ns_8s;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pp_pipeline_accel_divsub_22s_21ns_10ns_8s_if bus ();

  pp_pipeline_accel_divsub_22s_21ns_10ns_8s dut (
    .clk   (clk),
    .reset (rst),
    .ce    (ce),
    .bus   (bus)
  );

  typedef struct {
    logic [21:0] p;
    logic [20:0] c;
    logic [9:0]  b;
    logic [7:0]  q;
    logic [10:0] r;
    logic        ovf;
    logic        dz;
  } vec_t;

  // Launch one operation from idle and count edges after the accept edge until done.
  task automatic do_op(input logic [21:0] p, input logic [20:0] c, input logic [9:0] b,
                       output int n);
    bus.din0  = p;
    bus.din1  = b;
    bus.din2  = c;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; bus.start = 1'b0;
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", bus.dout); end
    checks++; if (bus.rem !== 11'h000) begin errors++; $display("FAIL reset_rem got %h want 000", bus.rem); end
    checks++; if ({bus.ovf, bus.div0} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.ovf, bus.div0}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t v[15];
    int   n;
    v[0]  = '{22'd1000,     21'd200,      10'd10,   8'h50, 11'h000, 1'b0, 1'b0};
    v[1]  = '{22'h3FFE0C,   21'd1000,     10'd300,  8'hFB, 11'h000, 1'b0, 1'b0};
    v[2]  = '{22'd0,        21'd37,       10'd5,    8'hF9, 11'h7FE, 1'b0, 1'b0};
    v[3]  = '{22'd100,      21'd1100,     10'd7,    8'h80, 11'h7FA, 1'b1, 1'b0};
    v[4]  = '{22'd50,       21'd0,        10'd0,    8'h7F, 11'h000, 1'b0, 1'b1};
    v[5]  = '{22'd0,        21'd5,        10'd0,    8'h80, 11'h000, 1'b0, 1'b1};
    v[6]  = '{22'h1FFFFF,   21'd0,        10'd1,    8'h7F, 11'h000, 1'b1, 1'b0};
    v[7]  = '{22'h3FFF80,   21'd0,        10'd1,    8'h80, 11'h000, 1'b0, 1'b0};
    v[8]  = '{22'h3FFF7F,   21'd0,        10'd1,    8'h80, 11'h000, 1'b1, 1'b0};
    v[9]  = '{22'd127,      21'd0,        10'd1,    8'h7F, 11'h000, 1'b0, 1'b0};
    v[10] = '{22'd128,      21'd0,        10'd1,    8'h7F, 11'h000, 1'b1, 1'b0};
    v[11] = '{22'h200000,   21'h1FFFFF,   10'd1023, 8'h80, 11'h7FD, 1'b1, 1'b0};
    v[12] = '{22'd5000,     21'd0,        10'd1023, 8'h04, 11'd908, 1'b0, 1'b0};
    v[13] = '{22'd200,      21'd200,      10'd3,    8'h00, 11'h000, 1'b0, 1'b0};
    v[14] = '{22'd23,       21'd0,        10'd0,    8'h7F, 11'h000, 1'b0, 1'b1};
    for (int i = 0; i < 15; i++) begin
      do_op(v[i].p, v[i].c, v[i].b, n);
      checks++; if (n !== 23) begin errors++; $display("FAIL vec%0d_latency got %0d want 23", i, n); end
      checks++; if (bus.dout !== v[i].q) begin errors++; $display("FAIL vec%0d_dout got %h want %h", i, bus.dout, v[i].q); end
      checks++; if (bus.rem !== v[i].r) begin errors++; $display("FAIL vec%0d_rem got %h want %h", i, bus.rem, v[i].r); end
      checks++; if (bus.ovf !== v[i].ovf) begin errors++; $display("FAIL vec%0d_ovf got %b want %b", i, bus.ovf, v[i].ovf); end
      checks++; if (bus.div0 !== v[i].dz) begin errors++; $display("FAIL vec%0d_div0 got %b want %b", i, bus.div0, v[i].dz); end
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL vec%0d_ready_at_done got %b want 1", i, bus.ready); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL vec%0d_done_falls got %b want 0", i, bus.done); end
    end
  endtask

  // Start held high: the second request is taken on the edge that ends the done cycle,
  // so done pulses land 23 and 47 edges after the first accept.
  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    int pulses = 0;
    bus.din0 = 22'd1000; bus.din1 = 10'd10; bus.din2 = 21'd200;
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        pulses++;
        if (d1 < 0) begin
          d1 = n;
          checks++; if (bus.dout !== 8'h50) begin errors++; $display("FAIL b2b_first_dout got %h want 50", bus.dout); end
          bus.din0 = 22'd0; bus.din1 = 10'd5; bus.din2 = 21'd37;
        end else if (d2 < 0) begin
          d2 = n;
          checks++; if (bus.dout !== 8'hF9) begin errors++; $display("FAIL b2b_second_dout got %h want f9", bus.dout); end
          checks++; if (bus.rem !== 11'h7FE) begin errors++; $display("FAIL b2b_second_rem got %h want 7fe", bus.rem); end
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (d1 !== 23) begin errors++; $display("FAIL b2b_first_latency got %0d want 23", d1); end
    checks++; if (d2 !== 47) begin errors++; $display("FAIL b2b_second_edge got %0d want 47", d2); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_busy_ignored();
    int d = -1;
    int extra = 0;
    int not_ready = 0;
    bus.din0 = 22'd1000; bus.din1 = 10'd10; bus.din2 = 21'd200;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin
        bus.start = 1'b1; bus.din0 = 22'd0; bus.din1 = 10'd5; bus.din2 = 21'd37;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", bus.ready); end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin
        if (d < 0) begin
          d = n;
          checks++; if (bus.dout !== 8'h50) begin errors++; $display("FAIL busy_dout got %h want 50", bus.dout); end
        end else extra++;
      end
      if (d > 0 && bus.ready !== 1'b1) not_ready++;
    end
    checks++; if (d !== 23) begin errors++; $display("FAIL busy_latency got %0d want 23", d); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_queued got %0d extra done want 0", extra); end
    checks++; if (not_ready !== 0) begin errors++; $display("FAIL busy_idle_ready got %0d low cycles want 0", not_ready); end
  endtask

  task automatic test_ce_stall();
    int d = -1;
    bus.din0 = 22'd0; bus.din1 = 10'd5; bus.din2 = 21'd37;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      ce = !(n >= 6 && n <= 10);
      @(posedge clk); #1;
      if (bus.done && d < 0) d = n;
      if (d > 0) break;
    end
    ce = 1'b1;
    checks++; if (d !== 28) begin errors++; $display("FAIL ce_latency got %0d want 28", d); end
    checks++; if (bus.dout !== 8'hF9) begin errors++; $display("FAIL ce_dout got %h want f9", bus.dout); end
    checks++; if (bus.rem !== 11'h7FE) begin errors++; $display("FAIL ce_rem got %h want 7fe", bus.rem); end
    ce = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ce_done_hold got %b want 1", bus.done); end
    ce = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL ce_done_fall got %b want 0", bus.done); end
  endtask

  task automatic test_reset_mid();
    int spurious = 0;
    int n;
    // Leave nonzero outputs behind so the reset clearing is visible.
    do_op(22'd100, 21'd1100, 10'd7, n);
    @(posedge clk); #1;
    bus.din0 = 22'd1000; bus.din1 = 10'd10; bus.din2 = 21'd200;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout got %h want 00", bus.dout); end
    checks++; if (bus.rem !== 11'h000) begin errors++; $display("FAIL rstmid_rem got %h want 000", bus.rem); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b want 0", bus.ovf); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.done) spurious++;
    end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d want 0", spurious); end
    do_op(22'd1000, 21'd200, 10'd10, n);
    checks++; if (n !== 23) begin errors++; $display("FAIL rstmid_next_latency got %0d want 23", n); end
    checks++; if (bus.dout !== 8'h50) begin errors++; $display("FAIL rstmid_next_dout got %h want 50", bus.dout); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_busy_ignored();
    test_ce_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
